// File: rtl/mini_fir_core.sv
// 7-tap streaming direct-form FIR with an 8-bit signed datapath.
// Three pipeline stages: delay line, registered products, then sum/shift/saturate.
module mini_fir_core #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_fir_ctrl,
  input  logic [COEF_W-1:0] i_coeff_00,
  input  logic [COEF_W-1:0] i_coeff_01,
  input  logic [COEF_W-1:0] i_coeff_02,
  input  logic [COEF_W-1:0] i_coeff_03,
  input  logic [COEF_W-1:0] i_coeff_04,
  input  logic [COEF_W-1:0] i_coeff_05,
  input  logic [COEF_W-1:0] i_coeff_06,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sat
);

  localparam int TAPS   = 7;
  localparam int PROD_W = DATA_W + COEF_W;
  // Three guard bits are enough for seven full-scale products.
  localparam int SUM_W  = PROD_W + 3;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(DATA_W-1) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(DATA_W-1)));

  logic                     enable;
  logic                     clear;
  logic [2:0]               shift_p2;
  logic                     unused_ctrl;
  logic                     accept;
  logic signed [COEF_W-1:0] coef [TAPS];

  logic signed [DATA_W-1:0] taps_p0 [TAPS];
  logic                     vld_p0;
  logic signed [PROD_W-1:0] prod_p1 [TAPS];
  logic                     vld_p1;
  logic signed [SUM_W-1:0]  sum_p1;
  logic signed [SUM_W-1:0]  shifted_p1;
  logic [DATA_W:0]          sat_res_p1;

  function automatic logic [DATA_W:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v > SAT_MAX)
      return {1'b1, SAT_MAX[DATA_W-1:0]};
    else if (v < SAT_MIN)
      return {1'b1, SAT_MIN[DATA_W-1:0]};
    else
      return {1'b0, v[DATA_W-1:0]};
  endfunction

  assign enable      = i_fir_ctrl[0];
  assign clear       = i_fir_ctrl[1];
  assign shift_p2    = i_fir_ctrl[4:2];
  assign unused_ctrl = ^i_fir_ctrl[7:5];
  assign accept      = i_valid & enable & ~clear;

  assign coef[0] = i_coeff_00;
  assign coef[1] = i_coeff_01;
  assign coef[2] = i_coeff_02;
  assign coef[3] = i_coeff_03;
  assign coef[4] = i_coeff_04;
  assign coef[5] = i_coeff_05;
  assign coef[6] = i_coeff_06;

  // Stage 0: delay line; clear wins over a simultaneous sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      for (int k = 0; k < TAPS; k++) taps_p0[k] <= '0;
    end else begin
      vld_p0 <= accept;
      if (clear) begin
        for (int k = 0; k < TAPS; k++) taps_p0[k] <= '0;
      end else if (accept) begin
        taps_p0[0] <= i_data;
        for (int k = 1; k < TAPS; k++) taps_p0[k] <= taps_p0[k-1];
      end
    end
  end

  // Stage 1: registered products against the coefficients present now
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      for (int k = 0; k < TAPS; k++) prod_p1[k] <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        for (int k = 0; k < TAPS; k++)
          prod_p1[k] <= PROD_W'(taps_p0[k]) * PROD_W'(coef[k]);
      end
    end
  end

  always_comb begin
    sum_p1 = '0;
    for (int k = 0; k < TAPS; k++) sum_p1 = sum_p1 + SUM_W'(prod_p1[k]);
    shifted_p1 = sum_p1 >>> shift_p2;
    sat_res_p1 = saturate(shifted_p1);
  end

  // Stage 2: output register, holds its value between valid outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= 1'b0;
    end else begin
      o_valid <= vld_p1;
      if (vld_p1) begin
        o_sat  <= sat_res_p1[DATA_W];
        o_data <= sat_res_p1[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mini_fir_core.sv
// Randomized and directed bench for mini_fir_core against a behavioural FIR model.
module tb_mini_fir_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_fir_ctrl;
  logic [7:0] c [7];
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_sat;

  always #5 clk = ~clk;

  mini_fir_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_fir_ctrl (i_fir_ctrl),
    .i_coeff_00 (c[0]),
    .i_coeff_01 (c[1]),
    .i_coeff_02 (c[2]),
    .i_coeff_03 (c[3]),
    .i_coeff_04 (c[4]),
    .i_coeff_05 (c[5]),
    .i_coeff_06 (c[6]),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_sat      (o_sat)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference state: accepted-sample history, newest first, plus the
  // sum awaiting its shift and the held output value.
  int hist [7];
  bit pend_mul;
  bit pend_out;
  int pend_sum;
  bit ev;
  int ed;
  bit es;
  int got_q [$];
  int sat_q [$];

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor_shift(input int s, input int sh);
    int d;
    d = 1 << sh;
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 7; k++) hist[k] = 0;
    pend_mul = 0;
    pend_out = 0;
    pend_sum = 0;
    ev = 0;
    ed = 0;
    es = 0;
  endtask

  task automatic model_edge();
    bit en, cl;
    int q, ci;
    en = i_fir_ctrl[0];
    cl = i_fir_ctrl[1];
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = pend_out;
    if (pend_out) begin
      q = floor_shift(pend_sum, int'(i_fir_ctrl[4:2]));
      if (q > 127) begin ed = 127; es = 1; end
      else if (q < -128) begin ed = -128; es = 1; end
      else begin ed = q; es = 0; end
    end
    pend_out = pend_mul;
    if (pend_mul) begin
      pend_sum = 0;
      for (int k = 0; k < 7; k++) begin
        ci = int'($signed(c[k]));
        pend_sum += ci * hist[k];
      end
    end
    if (cl) begin
      for (int k = 0; k < 7; k++) hist[k] = 0;
    end else if (en && i_valid) begin
      for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(i_data));
    end
    pend_mul = en && !cl && i_valid;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("o_valid", o_valid, ev);
    chk("o_data", $signed(o_data), ed);
    chk("o_sat", o_sat, es);
    if (o_valid === 1'b1) begin
      got_q.push_back(int'($signed(o_data)));
      sat_q.push_back(int'(o_sat));
    end
  endtask

  task automatic drive(input bit v, input int d);
    i_valid = v;
    i_data  = 8'(d);
  endtask

  task automatic set_ctrl(input bit en, input bit cl, input int sh);
    i_fir_ctrl = {3'b000, 3'(sh), cl, en};
  endtask

  task automatic ramp_coeffs();
    for (int k = 0; k < 7; k++) c[k] = 8'(k + 1);
  endtask

  task automatic impulse_expect(input string tag);
    got_q.delete();
    drive(1, 1);
    cycle();
    for (int i = 0; i < 6; i++) begin drive(1, 0); cycle(); end
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk({tag, "_count"}, got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) chk(tag, got_q[i], i + 1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    set_ctrl(0, 0, 0);
    for (int k = 0; k < 7; k++) c[k] = '0;
    drive(0, 0);
    #1;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_data", $signed(o_data), 0);
    chk("reset_o_sat", o_sat, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Impulse response with coefficients 1..7
    ramp_coeffs();
    set_ctrl(1, 0, 0);
    impulse_expect("impulse");
    foreach (sat_q[i]) chk("impulse_sat", sat_q[i], 0);

    // Saturation at both rails
    for (int k = 0; k < 7; k++) c[k] = 8'd127;
    got_q.delete(); sat_q.delete();
    for (int i = 0; i < 7; i++) begin drive(1, 127); cycle(); end
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("sat_pos_data", got_q[$], 127);
    chk("sat_pos_flag", sat_q[$], 1);
    got_q.delete(); sat_q.delete();
    for (int i = 0; i < 7; i++) begin drive(1, -128); cycle(); end
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("sat_neg_data", got_q[$], -128);
    chk("sat_neg_flag", sat_q[$], 1);

    // Arithmetic shift with floor
    c[0] = 8'd64;
    for (int k = 1; k < 7; k++) c[k] = '0;
    set_ctrl(1, 0, 3);
    got_q.delete();
    drive(1, 10);  cycle();
    drive(1, -3);  cycle();
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("shift_pos", got_q[0], 80);
    chk("shift_neg", got_q[1], -24);
    c[0] = 8'd1;
    set_ctrl(1, 0, 2);
    got_q.delete();
    drive(1, -3); cycle();
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("shift_floor", got_q[0], -1);

    // Clear drops the coincident sample and wipes history
    ramp_coeffs();
    set_ctrl(1, 0, 0);
    got_q.delete();
    for (int i = 0; i < 7; i++) begin drive(1, $urandom_range(1, 20)); cycle(); end
    set_ctrl(1, 1, 0);
    drive(1, 55);
    cycle();
    set_ctrl(1, 0, 0);
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("clear_drop_count", got_q.size(), 7);
    impulse_expect("post_clear");

    // Disable ignores new samples but lets the in-flight one emerge
    got_q.delete();
    drive(1, 9);
    cycle();
    set_ctrl(0, 0, 0);
    for (int i = 0; i < 5; i++) begin drive(1, 33); cycle(); end
    drive(0, 0);
    cycle();
    chk("disable_count", got_q.size(), 1);
    chk("disable_inflight", got_q[0], 9);

    // Reset in the middle of a continuous stream
    set_ctrl(1, 0, 0);
    for (int i = 0; i < 10; i++) begin drive(1, $urandom_range(0, 255)); cycle(); end
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_data", $signed(o_data), 0);
    chk("midrst_o_sat", o_sat, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    got_q.delete();
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();
    chk("post_rst_stale", got_q.size(), 0);
    impulse_expect("post_rst");

    // Randomized traffic, coefficients and control
    for (int k = 0; k < 7; k++) c[k] = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) c[$urandom_range(0, 6)] = 8'($urandom);
      i_fir_ctrl = {3'($urandom), 3'($urandom), $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) != 0};
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 255));
      cycle();
    end
    drive(0, 0);
    for (int i = 0; i < 4; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mini_fir_core.md
MINI_FIR_CORE -- requirements
Module: mini_fir_core

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  async active-low reset.
- i_fir_ctrl  in  8  control word from the FIR register block.
- i_coeff_00 .. i_coeff_06  in  8 each  signed tap coefficients; c00 applies to the newest sample.
- i_valid  in  1  input sample strobe.
- i_data  in  8  signed input sample.
- o_valid  out  1  output sample strobe.
- o_data  out  8  signed filtered output.
- o_sat  out  1  saturation flag, qualified by o_valid.
REQ-003 i_fir_ctrl fields SHALL be: bit0 enable, bit1 clear, bits[4:2] shift (0..7), bits[7:5] reserved and ignored.

Function
REQ-004 Block SHALL be a 7-tap streaming direct-form FIR, y[n] = sum over k=0..6 of c0k * x[n-k], with no backpressure.
REQ-005 Sample acceptance SHALL occur when i_valid=1 and enable=1 and clear=0; an accepted sample shifts the 7-entry delay line (tap0 <= i_data, tapk <= tapk-1).
REQ-006 When enable=0, i_valid SHALL be ignored: no shift and no output generated.
REQ-007 When clear=1, all 7 taps SHALL be zeroed at the next edge; clear beats a simultaneous i_valid and that sample is dropped with no o_valid.
REQ-008 Enable and clear SHALL NOT affect samples already past the delay line; in-flight results drain normally.
REQ-009 Pipeline SHALL have three stages: delay-line update; registered 7 signed 16-bit products; registered sum/shift/saturate.
REQ-010 Latency SHALL be fixed: i_valid accepted in cycle t -> o_valid=1 for exactly cycle t+3, one output per accepted sample; back-to-back inputs give back-to-back outputs.
REQ-011 Products SHALL use the coefficient values present in cycle t+1; coefficient changes are not synchronised further.
REQ-012 All multiplies SHALL be signed two's complement 8x8 -> 16 bit, and the sum SHALL be held in at least 19 bits signed with no overflow.
REQ-013 The sum SHALL be arithmetically right-shifted by the shift field (floor, no rounding).
REQ-014 The shifted value SHALL then be clamped to [-128, 127] into o_data, with o_sat=1 iff clamping occurred.
REQ-015 o_data and o_sat SHALL hold their last value while o_valid=0.

Reset
REQ-016 rst_n low SHALL immediately force taps, product registers, o_valid, o_data and o_sat to 0, regardless of pipeline occupancy.
REQ-017 Samples in flight at reset SHALL be discarded and produce no o_valid after reset release.
REQ-018 The first accepted sample after release SHALL see zero history.

Verification
REQ-019 Impulse: coeffs 1..7, shift 0, enable=1; send 1 then six 0s -> o_data 1,2,3,4,5,6,7 on consecutive cycles starting 3 cycles after the 1; o_sat=0.
REQ-020 Saturation: all coeffs 127; seven samples of 127 -> final o_data=127, o_sat=1. Seven samples of -128 -> o_data=-128, o_sat=1.
REQ-021 Shift: c00=64, others 0, shift=3; x=10 -> 80; x=-3 -> -24 (floor).
REQ-022 Clear and enable: after filling taps, clear=1 with i_valid=1 -> no o_valid for that sample, and the next impulse gives a clean response. With enable=0 and i_valid pulses -> no o_valid, while a sample already in flight still emerges.
REQ-023 Reset mid-stream: rst_n low during continuous input -> o_valid, o_data and o_sat are 0 at once, with no stale outputs after release.
